// File: rtl/tour_cmd_seq.sv
// tour_cmd_seq: knight's-tour leg sequencer sharing the command port with UART; TOUR_FANFARE_EN selects fanfare opcode on horizontal legs
module tour_cmd_seq #(
   parameter int NUM_MOVES = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_tour,
   input  logic [7:0]  move,
   output logic [4:0]  mv_indx,
   input  logic [15:0] cmd_UART,
   input  logic        cmd_rdy_UART,
   output logic        clr_cmd_rdy_UART,
   input  logic        clr_cmd_rdy,
   input  logic        send_resp,
   output logic [15:0] cmd,
   output logic        cmd_rdy,
   output logic [7:0]  resp
);
   typedef enum logic [2:0] {IDLE, LATCH, VERT, VERT_W, HORZ, HORZ_W} state_t;
`ifdef TOUR_FANFARE_EN
   localparam logic [3:0] H_OP = 4'b0101;
`else
   localparam logic [3:0] H_OP = 4'b0100;
`endif
   localparam logic [4:0] LAST = 5'(NUM_MOVES - 1);
   state_t state;
   logic [7:0] mv_reg;
   logic [2:0] lo;
   logic [15:0] vert_cmd, horz_cmd;
   always_comb begin
      lo = 3'd0;
      for (int i = 7; i >= 0; i--) if (mv_reg[i]) lo = 3'(i);
   end
   // lowest set bit selects the move; bits 0..7 map to (dy,dx) around the board
   always_comb begin
      vert_cmd = {4'b0100, (lo inside {3'd0, 3'd1, 3'd2, 3'd7}) ? 8'h00 : 8'h7F, 2'b00,
                  (lo inside {3'd0, 3'd1, 3'd4, 3'd5}) ? 2'd2 : 2'd1};
      horz_cmd = {H_OP, (lo inside {3'd0, 3'd5, 3'd6, 3'd7}) ? 8'hBF : 8'h3F, 2'b00,
                  (lo inside {3'd2, 3'd3, 3'd6, 3'd7}) ? 2'd2 : 2'd1};
   end
   assign cmd = state == IDLE ? cmd_UART : (state == HORZ || state == HORZ_W) ? horz_cmd : vert_cmd;
   assign cmd_rdy = state == IDLE ? cmd_rdy_UART : (state == VERT || state == HORZ);
   assign clr_cmd_rdy_UART = state == IDLE && clr_cmd_rdy;
   always_ff @(posedge clk)
      if (!rst_n) begin
         state <= IDLE;
         mv_indx <= '0;
         mv_reg <= '0;
         resp <= 8'hA5;
      end else
         case (state)
            IDLE: if (start_tour) begin
               mv_indx <= '0;
               state <= LATCH;
            end
            LATCH: begin
               mv_reg <= move;
               if (move == '0) begin
                  resp <= 8'hA5;
                  state <= IDLE;
               end else state <= VERT;
            end
            VERT: if (clr_cmd_rdy) state <= VERT_W;
            VERT_W: if (send_resp) state <= HORZ;
            HORZ: if (clr_cmd_rdy) state <= HORZ_W;
            HORZ_W: if (send_resp) begin
               if (mv_indx == LAST) begin
                  resp <= 8'hA5;
                  state <= IDLE;
               end else begin
                  mv_indx <= mv_indx + 5'd1;
                  resp <= 8'h5A;
                  state <= LATCH;
               end
            end
            default: state <= IDLE;
         endcase
endmodule

// File: tb/tb_tour_cmd_seq.sv
// tb_tour_cmd_seq: random tours scored against a move-table model; a processor-model monitor consumes every command
module tb_tour_cmd_seq;
`ifdef TOUR_FANFARE_EN
   localparam logic [3:0] FAN_OP = 4'h5;
`else
   localparam logic [3:0] FAN_OP = 4'h4;
`endif
   typedef struct {
      logic [15:0] cmd;
      bit          uart;
      bit          has_resp;
      logic [7:0]  resp;
      logic [4:0]  idx;
   } exp_t;
   logic clk = 0;
   logic rst_n, start_tour, clr_cmd_rdy, send_resp, cmd_rdy_UART, clr_cmd_rdy_UART, cmd_rdy;
   logic start_s, clr_s, clr_m, sr_s, sr_m, mon_en, busy;
   logic [15:0] cmd_UART, cmd;
   logic [7:0] move, resp;
   logic [4:0] mv_indx;
   logic [7:0] mem [32];
   int uart_set = 0, uart_clr = 0, checks = 0, errors = 0;
   exp_t q[$];
   exp_t e_m;
   assign move = mem[mv_indx];
   assign start_tour = start_s;
   assign clr_cmd_rdy = clr_s | clr_m;
   assign send_resp = sr_s | sr_m;
   assign cmd_rdy_UART = uart_set != uart_clr;
   always #5 clk = ~clk;
   tour_cmd_seq #(.NUM_MOVES(24)) dut (
      .clk(clk), .rst_n(rst_n), .start_tour(start_tour), .move(move), .mv_indx(mv_indx),
      .cmd_UART(cmd_UART), .cmd_rdy_UART(cmd_rdy_UART), .clr_cmd_rdy_UART(clr_cmd_rdy_UART),
      .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .cmd(cmd), .cmd_rdy(cmd_rdy), .resp(resp)
   );
   task automatic chk(string name, logic [15:0] got, logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask
   function automatic logic [15:0] leg(logic [7:0] m, bit horiz);
      int dys[8], dxs[8];
      int b, d, a;
      dys = '{2, 2, 1, -1, -2, -2, -1, 1};
      dxs = '{1, -1, -2, -2, -1, 1, 2, 2};
      b = 0;
      for (int i = 0; i < 8; i++) if (m[i]) begin
         b = i;
         break;
      end
      d = horiz ? dxs[b] : dys[b];
      a = d < 0 ? -d : d;
      if (!horiz) return {4'h4, d > 0 ? 8'h00 : 8'h7F, 4'(a)};
      return {FAN_OP, d > 0 ? 8'hBF : 8'h3F, 4'(a)};
   endfunction
   task automatic push_tour();
      exp_t x;
      for (int i = 0; i < 24; i++) begin
         if (mem[i] == 8'h00) break;
         x.uart = 0;
         x.idx = 5'(i);
         x.cmd = leg(mem[i], 0);
         x.has_resp = 0;
         x.resp = 8'h00;
         q.push_back(x);
         x.cmd = leg(mem[i], 1);
         x.has_resp = 1;
         x.resp = i == 23 ? 8'hA5 : 8'h5A;
         q.push_back(x);
      end
   endtask
   task automatic push_uart(logic [15:0] c);
      exp_t x;
      x.cmd = c;
      x.uart = 1;
      x.has_resp = 1;
      x.resp = 8'hA5;
      x.idx = 5'd0;
      q.push_back(x);
   endtask
   task automatic wait_done();
      int n = 0;
      while ((q.size() != 0 || busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 3000) begin
         checks++;
         errors++;
         $display("FAIL timeout: %0d commands outstanding, expected 0", q.size());
      end
   endtask
   task automatic do_leg(logic [15:0] exp);
      int n = 0;
      while (!cmd_rdy && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("man_rdy", 16'(cmd_rdy), 16'd1);
      chk("man_cmd", cmd, exp);
      clr_s = 1;
      @(negedge clk);
      clr_s = 0;
      @(negedge clk);
      sr_s = 1;
      @(negedge clk);
      sr_s = 0;
   endtask
   // processor model: consumes whatever the DUT presents and scores it against the queue head
   initial begin
      clr_m = 0;
      sr_m = 0;
      busy = 0;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && cmd_rdy) begin
            busy = 1;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cmd: got %h expected none", cmd);
            end else begin
               e_m = q.pop_front();
               chk("cmd", cmd, e_m.cmd);
               if (!e_m.uart) chk("mv_indx", 16'(mv_indx), 16'(e_m.idx));
               repeat ($urandom_range(0, 2)) @(negedge clk);
               chk("cmd_hold", cmd, e_m.cmd);
               clr_m = 1;
               #1 chk("clr_uart", 16'(clr_cmd_rdy_UART), 16'(e_m.uart));
               @(negedge clk);
               clr_m = 0;
               if (e_m.uart) uart_clr++;
               #1 chk("cmd_rdy_fall", 16'(cmd_rdy), 16'd0);
               repeat ($urandom_range(0, 3)) @(negedge clk);
               sr_m = 1;
               @(negedge clk);
               sr_m = 0;
               if (e_m.has_resp) chk("resp", 16'(resp), 16'(e_m.resp));
            end
            busy = 0;
         end
      end
   end
   initial begin
      logic [15:0] u;
      rst_n = 0;
      start_s = 0;
      clr_s = 0;
      sr_s = 0;
      mon_en = 0;
      cmd_UART = 16'h1234;
      u = 16'h0;
      for (int i = 0; i < 32; i++) mem[i] = 8'h01;
      repeat (3) @(negedge clk);
      chk("rst_mv_indx", 16'(mv_indx), 16'd0);
      chk("rst_resp", 16'(resp), 16'hA5);
      chk("rst_cmd_rdy", 16'(cmd_rdy), 16'd0);
      chk("rst_cmd", cmd, 16'h1234);
      rst_n = 1;
      @(negedge clk);
      cmd_UART = 16'h2000;
      uart_set++;
      clr_s = 1;
      #1;
      chk("pt_cmd", cmd, 16'h2000);
      chk("pt_cmd_rdy", 16'(cmd_rdy), 16'd1);
      chk("pt_clr_uart", 16'(clr_cmd_rdy_UART), 16'd1);
      chk("pt_resp", 16'(resp), 16'hA5);
      clr_s = 0;
      push_uart(16'h2000);
      mon_en = 1;
      wait_done();
      for (int t = 0; t < 4; t++) begin
         int k;
         k = 24;
         for (int i = 0; i < 32; i++) mem[i] = 8'(1 << $urandom_range(0, 7));
         if (t == 0) begin
            mem[0] = 8'h01;
            mem[1] = 8'h08;
         end
         if (t == 1) for (int i = 0; i < 24; i += 3) mem[i] = 8'($urandom_range(1, 255));
         if (t == 2) begin
            k = $urandom_range(1, 22);
            mem[k] = 8'h00;
         end
         if (t == 3) begin
            k = 0;
            mem[0] = 8'h00;
         end
         push_tour();
         if (t == 1) begin
            u = 16'($urandom);
            push_uart(u);
         end
         @(negedge clk);
         start_s = 1;
         @(negedge clk);
         start_s = 0;
         if (t == 1) begin
            repeat (6) @(negedge clk);
            cmd_UART = u;
            uart_set++;
            repeat (4) @(negedge clk);
            start_s = 1;
            @(negedge clk);
            start_s = 0;
         end
         wait_done();
         repeat (4) @(negedge clk);
         chk("end_resp", 16'(resp), 16'hA5);
         chk("end_mv_indx", 16'(mv_indx), 16'(k == 24 ? 23 : k));
         chk("end_idle", 16'(cmd_rdy), 16'd0);
      end
      mon_en = 0;
      for (int i = 0; i < 32; i++) mem[i] = 8'(1 << $urandom_range(0, 7));
      @(negedge clk);
      start_s = 1;
      @(negedge clk);
      start_s = 0;
      do_leg(leg(mem[0], 0));
      do_leg(leg(mem[0], 1));
      chk("man_resp", 16'(resp), 16'h5A);
      do_leg(leg(mem[1], 0));
      chk("pre_rst_rdy", 16'(cmd_rdy), 16'd1);
      chk("pre_rst_cmd", cmd, leg(mem[1], 1));
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      chk("post_rst_mv_indx", 16'(mv_indx), 16'd0);
      chk("post_rst_resp", 16'(resp), 16'hA5);
      chk("post_rst_cmd_rdy", 16'(cmd_rdy), 16'd0);
      chk("post_rst_cmd", cmd, cmd_UART);
      @(negedge clk);
      chk("post_rst_idle", 16'(cmd_rdy), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/tour_cmd_seq.md
# tour_cmd_seq

Sequences the knight's-tour move list into move commands for the command processor, and shares the processor's command port between the UART command path and the tour. Idle: UART commands pass straight through. After `start_tour`: the block reads one-hot moves from the tour-solution store by index. Each knight move becomes two legs: vertical first, then horizontal. Each leg is issued with the same `cmd_rdy`/`clr_cmd_rdy`/`send_resp` handshake the processor uses for UART commands.

## Interface
Parameters:
- `NUM_MOVES`, default 24: moves per tour (5x5 board). Legal range 1..32.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  synchronous active-low reset
- `start_tour`  in  1  pulse from tour solver; tour begins
- `move`  in  8  one-hot move at `mv_indx`; valid one cycle after `mv_indx` changes
- `mv_indx`  out  5  index of move being read
- `cmd_UART`  in  16  command from UART wrapper
- `cmd_rdy_UART`  in  1  UART command pending
- `clr_cmd_rdy_UART`  out  1  clear to UART wrapper
- `clr_cmd_rdy`  in  1  command processor consumed `cmd`
- `send_resp`  in  1  command processor finished a command
- `cmd`  out  16  command to processor
- `cmd_rdy`  out  1  `cmd` valid
- `resp`  out  8  response byte to UART transmitter

## Operation
Command format:
- `cmd[15:12]` = 4'b0100 (move) or 4'b0101 (move with fanfare).
- `cmd[11:4]` = heading: North 8'h00, West 8'h3F, South 8'h7F, East 8'hBF.
- `cmd[3:0]` = squares: 1 or 2.

Move encoding (dy, dx), where +dy = North and +dx = East:
- bit0 (+2,+1), bit1 (+2,-1), bit2 (+1,-2), bit3 (-1,-2)
- bit4 (-2,-1), bit5 (-2,+1), bit6 (-1,+2), bit7 (+1,+2)
- Non-one-hot `move`: the lowest set bit wins.

Legs:
- Vertical leg: heading North if dy>0, else South; squares = |dy|; opcode 4'b0100.
- Horizontal leg: heading East if dx>0, else West; squares = |dx|; opcode per Configuration.

States:
- IDLE
  - `cmd` = `cmd_UART`, `cmd_rdy` = `cmd_rdy_UART`, `clr_cmd_rdy_UART` = `clr_cmd_rdy` (combinational pass-through).
  - `start_tour` -> `mv_indx` <= 0, go to LATCH.
- LATCH: `mv_reg` <= `move`.
  - `move` == 0 -> abort to IDLE, `resp` <= 8'hA5.
  - Otherwise go to VERT.
- VERT: `cmd_rdy` = 1, `cmd` = vertical leg. `clr_cmd_rdy` -> VERT_W.
- VERT_W: `cmd_rdy` = 0. `send_resp` -> HORZ.
- HORZ: `cmd_rdy` = 1, `cmd` = horizontal leg. `clr_cmd_rdy` -> HORZ_W.
- HORZ_W: `cmd_rdy` = 0. On `send_resp`:
  - If `mv_indx` == NUM_MOVES-1: `resp` <= 8'hA5, go to IDLE.
  - Otherwise: `mv_indx` <= `mv_indx`+1, `resp` <= 8'h5A, go to LATCH.

Rules:
- Outside IDLE, `clr_cmd_rdy_UART` = 0. `cmd_rdy_UART` stays pending and is serviced on return to IDLE.
- `start_tour` is ignored outside IDLE.
- `send_resp` is ignored outside VERT_W/HORZ_W.
- `clr_cmd_rdy` is ignored outside VERT/HORZ.
- Outside IDLE, `cmd` is driven from `mv_reg` only; `move` changes after LATCH have no effect.
- `resp` holds its value until next updated.

## Timing
- Reset values:
  - state IDLE, `mv_indx` 0, `mv_reg` 0, `resp` 8'hA5.
  - `cmd_rdy` = `cmd_rdy_UART`; `cmd` = `cmd_UART`; `clr_cmd_rdy_UART` = `clr_cmd_rdy` (pass-through).
- `start_tour` at cycle N: LATCH at N+1, `cmd_rdy` = 1 at N+2.
- `cmd_rdy` falls the cycle after `clr_cmd_rdy` is sampled high.
- HORZ_W `send_resp` at cycle M: LATCH at M+1 (new `mv_indx`), next VERT `cmd_rdy` at M+2.
- `rst_n` low at any state: next edge forces the reset values. A leg in progress is dropped with no response.

## Configuration
- `TOUR_FANFARE_EN` defined: horizontal legs use opcode 4'b0101, so the processor plays fanfare at the end of each knight move.
- Undefined: horizontal legs use 4'b0100. Vertical legs are always 4'b0100.

## Test plan
- Idle pass-through: `cmd_UART`=16'h2000, `cmd_rdy_UART`=1, `clr_cmd_rdy`=1 -> `cmd`=16'h2000, `cmd_rdy`=1, `clr_cmd_rdy_UART`=1 in the same cycle; `resp`=8'hA5.
- Single move, `move`=8'h01, NUM_MOVES=1:
  - `cmd`=16'h4002 (North 2), then `cmd`=16'h5BF1 (East 1, fanfare enabled; 16'h4BF1 without).
  - Final `send_resp` -> `resp`=8'hA5, state IDLE.
- `move`=8'h08 -> `cmd` 16'h47F1 (South 1), then 16'h53F2 (West 2, fanfare enabled).
- NUM_MOVES=24 tour with handshakes 3 cycles apart:
  - `mv_indx` steps 0..23, 48 commands issued.
  - `resp`=8'h5A after each of moves 0..22, 8'hA5 after move 23.
- `cmd_rdy_UART`=1 during VERT_W -> `clr_cmd_rdy_UART` stays 0 and `cmd` is not UART; after tour end, UART command forwarded.
- `move`=0 at LATCH -> no `cmd_rdy`, return to IDLE, `resp`=8'hA5.
- `rst_n`=0 in HORZ -> next cycle IDLE, `mv_indx`=0.
